// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the E stage. It owns HI/LO, computes the
// result at the start edge and holds it back until a fixed busy window expires.
module e_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDUA,
    input  logic [31:0] E_MDUB,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    // Signed 32x32 product via sign extension to 64 bits; the low 64 bits are exact.
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}; a zero divisor is replaced so the result stays defined.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (b == 32'd0) ? 32'd1 : b;
        return {a % d, a / d};
    endfunction

    // Magnitude division, then quotient sign from both operands and remainder sign
    // from the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [63:0] ur;
        logic [31:0] q;
        logic [31:0] r;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        ur    = div_unsigned(mag_a, mag_b);
        q     = (a[31] ^ b[31]) ? (32'd0 - ur[31:0]) : ur[31:0];
        r     = a[31] ? (32'd0 - ur[63:32]) : ur[63:32];
        return {r, q};
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic             commit_ok_q, commit_ok_d;

    logic             is_mul_s;
    logic             is_div_s;
    logic             start_ok_s;
    logic             idle_s;
    logic [63:0]      result_s;

    // Decode the op and evaluate the arithmetic result from the live operands.
    always_comb begin
        is_mul_s   = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
        is_div_s   = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
        idle_s     = (cnt_q == CNT_ZERO);
        start_ok_s = E_Start && idle_s && (is_mul_s || is_div_s);
        case (E_MDUOp)
            OP_MULT:  result_s = mul_signed(E_MDUA, E_MDUB);
            OP_MULTU: result_s = mul_unsigned(E_MDUA, E_MDUB);
            OP_DIV:   result_s = div_signed(E_MDUA, E_MDUB);
            OP_DIVU:  result_s = div_unsigned(E_MDUA, E_MDUB);
            default:  result_s = 64'd0;
        endcase
    end

    // Next-state: start latches the result, countdown commits on 1->0, idle accepts MTHI/MTLO.
    always_comb begin
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        tmp_hi_d    = tmp_hi_q;
        tmp_lo_d    = tmp_lo_q;
        commit_ok_d = commit_ok_q;
        if (start_ok_s) begin
            cnt_d       = is_mul_s ? MUL_LOAD : DIV_LOAD;
            tmp_hi_d    = result_s[63:32];
            tmp_lo_d    = result_s[31:0];
            commit_ok_d = !(is_div_s && (E_MDUB == 32'd0));
        end else if (!idle_s) begin
            cnt_d = cnt_q - CNT_ONE;
            hi_d  = ((cnt_q == CNT_ONE) && commit_ok_q) ? tmp_hi_q : hi_q;
            lo_d  = ((cnt_q == CNT_ONE) && commit_ok_q) ? tmp_lo_q : lo_q;
        end else begin
            case (E_MDUOp)
                OP_MTHI: hi_d = E_MDUA;
                OP_MTLO: lo_d = E_MDUA;
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= CNT_ZERO;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            tmp_hi_q    <= 32'd0;
            tmp_lo_q    <= 32'd0;
            commit_ok_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            tmp_hi_q    <= tmp_hi_d;
            tmp_lo_q    <= tmp_lo_d;
            commit_ok_q <= commit_ok_d;
        end
    end

    // Busy and move-from read port; MFHI/MFLO see only committed values.
    always_comb begin
        E_Busy = !idle_s || E_Start;
        case (E_MDUOp)
            OP_MFHI: E_MDUOut = hi_q;
            OP_MFLO: E_MDUOut = lo_q;
            default: E_MDUOut = 32'd0;
        endcase
    end

    assign E_HI = hi_q;
    assign E_LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed and randomized bench for e_mdu, checked against a plain-arithmetic
// reference model of HI/LO and the busy window.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mout;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUA   (a),
        .E_MDUB   (b),
        .E_MDUOp  (op),
        .E_Start  (start),
        .E_Busy   (busy),
        .E_HI     (hi),
        .E_LO     (lo),
        .E_MDUOut (mout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO} from the architectural definition.
    function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        case (o)
            4'd1:    r = 64'(sa * sb);
            4'd2:    r = {32'd0, xa} * {32'd0, xb};
            4'd3:    r = {32'(sa % sb), 32'(sa / sb)};
            4'd4:    r = {xa % xb, xa / xb};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Issue one MD op, check busy for start cycle + N, hold of HI/LO, then the commit.
    task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit commit);
        int n;
        n = (o <= 4'd2) ? 5 : 10;
        op = o; a = xa; b = xb; start = 1'b1;
        #2;
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        tick;
        start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
        for (int k = 0; k < n; k++) begin
            #2;
            chk({tag, "_busy_cnt"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold_hi"}, hi, m_hi);
            chk({tag, "_hold_lo"}, lo, m_lo);
            tick;
        end
        #2;
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        if (commit) begin
            m_hi = exp_hi;
            m_lo = exp_lo;
        end
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        op = o; a = v; start = 1'($urandom_range(0, 1));
        tick;
        op = 4'd0; start = 1'b0;
        if (o == 4'd5) m_hi = v;
        else m_lo = v;
        #2;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
        chk("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic mf;
        op = 4'd7; #1;
        chk("mfhi", mout, m_hi);
        op = 4'd8; #1;
        chk("mflo", mout, m_lo);
        op = 4'd0; #1;
        chk("mf_none", mout, 32'd0);
        tick;
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          w;

        reset = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; start = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) tick;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick;

        run_md("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        run_md("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        run_md("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        run_md("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b1);
        run_md("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);
        mf;

        // Divide by zero keeps the busy window but leaves HI/LO alone.
        mt(4'd5, 32'h11);
        run_md("div0", 4'd3, 32'd123, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("div0_hi_const", hi, 32'h11);
        run_md("divu0", 4'd4, 32'd77, 32'd0, 32'd0, 32'd0, 1'b0);

        // MTLO and a second start during a MULT are both ignored.
        op = 4'd1; a = 32'd7; b = 32'd6; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd6; a = 32'h55;
        tick;
        tick;
        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd0;
        #1;
        w = 0;
        while (busy && w < 20) begin
            tick;
            w++;
        end
        chk("mult_busy_wait", 32'(w), 32'd2);
        m_hi = 32'd0; m_lo = 32'd42;
        chk("mtlo_ign_lo", lo, m_lo);
        chk("mtlo_ign_hi", hi, m_hi);
        mt(4'd6, 32'h55);
        chk("mtlo_lo_const", lo, 32'h55);
        mf;

        // Start with a non-MD op does not open a busy window.
        op = 4'd0; start = 1'b1;
        tick;
        op = 4'd7;
        tick;
        start = 1'b0; op = 4'd0;
        #1;
        chk("badop_busy", {31'd0, busy}, 32'd0);
        chk("badop_hi", hi, m_hi);
        chk("badop_lo", lo, m_lo);

        // Reset mid-DIV with four cycles left: cleared at once, no late commit.
        mt(4'd5, 32'hAA);
        mt(4'd6, 32'hBB);
        op = 4'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd0;
        repeat (6) tick;
        reset = 1'b0;
        #1;
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        tick;
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("rst_nocommit_hi", hi, 32'd0);
            chk("rst_nocommit_lo", lo, 32'd0);
        end

        // Randomized operations with corner operands mixed in.
        for (int i = 0; i < 24; i++) begin
            ro = 4'(1 + ($urandom % 4));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = 32'd0;
            if (i % 6 == 1) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if (i % 6 == 2) rb = 32'(($urandom % 9) + 1);
            if ((ro >= 4'd3) && (rb == 32'd0)) begin
                run_md("rnd_div0", ro, ra, rb, 32'd0, 32'd0, 1'b0);
            end else begin
                r = ref_md(ro, ra, rb);
                run_md("rnd", ro, ra, rb, r[63:32], r[31:0], 1'b1);
            end
            if (i % 4 == 3) begin
                mt(4'(5 + (i % 2)), $urandom);
                mf;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
